// File: rtl/spi_byte_sequencer_if.sv
// Host and SPI-driver signal bundle for spi_byte_sequencer.
// slave is the sequencer's view; master is the view of whatever surrounds it.
interface spi_byte_sequencer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       wr_last;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic [7:0] drv_data_in;
  logic       drv_start;
  logic       drv_done;
  logic [7:0] drv_data_out;
  logic       cs_n;
  logic       busy;

  modport slave (
    input  wr_valid, wr_data, wr_last, rd_ready, drv_done, drv_data_out,
    output wr_ready, rd_valid, rd_data, drv_data_in, drv_start, cs_n, busy
  );

  modport master (
    output wr_valid, wr_data, wr_last, rd_ready, drv_done, drv_data_out,
    input  wr_ready, rd_valid, rd_data, drv_data_in, drv_start, cs_n, busy
  );
endinterface

// File: rtl/spi_byte_sequencer.sv
// Frames queued TX bytes into SPI transfers: cs_n setup/hold timing, one
// driver request per byte, and received bytes collected into an RX FIFO.
module spi_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end
endmodule

module spi_byte_sequencer #(
  parameter int DEPTH    = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_byte_sequencer_if.slave  bus
);
  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE, SETUP, ISSUE, WAIT, CAPTURE, RELEASE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cs_n;
  logic             r_drv_start;
  logic [7:0]       r_drv_data_in;
  logic             r_cur_last;
  logic [7:0]       r_rx_hold;
  logic             r_captured;
  logic             r_busy;

  logic       w_tx_push;
  logic       w_tx_pop;
  logic [8:0] w_tx_head;
  logic       w_tx_full;
  logic       w_tx_empty;
  logic       w_rx_push;
  logic       w_rx_pop;
  logic [7:0] w_rx_head;
  logic       w_rx_full;
  logic       w_rx_empty;

  assign w_tx_push = bus.wr_valid && !w_tx_full;
  assign w_tx_pop  = (r_state == ISSUE);
  assign w_rx_pop  = bus.rd_ready && !w_rx_empty;
  // r_captured marks a CAPTURE that already pushed and now waits for TX data.
  assign w_rx_push = (r_state == CAPTURE) && !r_captured && (!w_rx_full || w_rx_pop);

  spi_seq_fifo #(.WIDTH(9), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_pop),
    .i_data  ({bus.wr_last, bus.wr_data}),
    .o_data  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  spi_seq_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop),
    .i_data  (r_rx_hold),
    .o_data  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  assign bus.wr_ready    = !w_tx_full;
  assign bus.rd_valid    = !w_rx_empty;
  assign bus.rd_data     = w_rx_head;
  assign bus.drv_data_in = r_drv_data_in;
  assign bus.drv_start   = r_drv_start;
  assign bus.cs_n        = r_cs_n;
  assign bus.busy        = r_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_cs_n        <= 1'b1;
      r_drv_start   <= 1'b0;
      r_drv_data_in <= '0;
      r_cur_last    <= 1'b0;
      r_rx_hold     <= '0;
      r_captured    <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_drv_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_tx_empty) begin
            r_state <= SETUP;
            r_cnt   <= CNT_W'(CS_SETUP - 1);
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        SETUP: begin
          if (r_cnt == '0) begin
            r_state       <= ISSUE;
            r_drv_start   <= 1'b1;
            r_drv_data_in <= w_tx_head[7:0];
            r_cur_last    <= w_tx_head[8];
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ISSUE: begin
          r_state <= WAIT;
        end
        WAIT: begin
          if (bus.drv_done) begin
            r_rx_hold  <= bus.drv_data_out;
            r_captured <= 1'b0;
            r_state    <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (w_rx_push && r_cur_last) begin
            r_state <= RELEASE;
            r_cs_n  <= 1'b1;
            r_cnt   <= CNT_W'(CS_HOLD - 1);
          end else if ((w_rx_push || r_captured) && !w_tx_empty) begin
            r_state       <= ISSUE;
            r_drv_start   <= 1'b1;
            r_drv_data_in <= w_tx_head[7:0];
            r_cur_last    <= w_tx_head[8];
          end else if (w_rx_push) begin
            r_captured <= 1'b1;
          end
        end
        RELEASE: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cs_n  <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/spi_byte_sequencer.md
SPI_BYTE_SEQUENCER -- requirements
Module: spi_byte_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, meaning entries in each of the TX and RX FIFOs; power of two, 2..16.
REQ-002 Parameter CS_SETUP, default 2, meaning clk cycles cs_n is held low before the first drv_start of a frame.
REQ-003 Parameter CS_HOLD, default 2, meaning clk cycles cs_n is held high after a frame, before the next frame may begin.
REQ-004 clk  input  1  single clock; all logic is on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 wr_valid  input  1  host offers a TX byte.
REQ-007 wr_ready  output  1  TX FIFO can accept a byte; equals !tx_full.
REQ-008 wr_data  input  8  TX byte.
REQ-009 wr_last  input  1  this byte ends the frame; stored with the byte in the TX FIFO.
REQ-010 rd_valid  output  1  RX FIFO holds at least one byte; equals !rx_empty.
REQ-011 rd_ready  input  1  host consumes the RX head byte.
REQ-012 rd_data  output  8  RX FIFO head byte; 0 when empty.
REQ-013 drv_data_in  output  8  byte presented to the SPI driver.
REQ-014 drv_start  output  1  one-cycle request to the driver to shift drv_data_in.
REQ-015 drv_done  input  1  one-cycle pulse from the driver; the byte is complete.
REQ-016 drv_data_out  input  8  byte received by the driver; valid in the drv_done cycle.
REQ-017 cs_n  output  1  chip select, active-low, framed by the sequencer.
REQ-018 busy  output  1  high whenever state != IDLE.

Function
REQ-019 TX FIFO write: a push occurs when wr_valid && wr_ready; data and last flag are written at the write pointer.
REQ-020 FIFO pointers: both FIFOs wrap from DEPTH-1 to 0 and track full/empty with a count of width clog2(DEPTH)+1.
REQ-021 Simultaneous push and pop on either FIFO: both take effect in the same cycle; the count is unchanged.
REQ-022 Full FIFO: a push is blocked unless a pop occurs in the same cycle. Empty FIFO: a pop is ignored.
REQ-023 States: IDLE, SETUP, ISSUE, WAIT, CAPTURE, RELEASE.
REQ-024 IDLE: cs_n=1; if the TX FIFO is non-empty, go to SETUP next cycle and load the setup counter with CS_SETUP-1.
REQ-025 SETUP: cs_n=0; count down; at 0 go to ISSUE.
REQ-026 ISSUE (exactly one cycle):
- pop the TX head and register its data to drv_data_in and its last flag to cur_last;
- assert drv_start for this cycle only;
- go to WAIT.
REQ-027 WAIT: cs_n=0 and drv_start=0; hold until drv_done; on drv_done latch drv_data_out into rx_hold and go to CAPTURE.
REQ-028 A drv_done pulse outside WAIT shall be ignored.
REQ-029 CAPTURE, RX FIFO not full (or popped this cycle): push rx_hold, then:
- cur_last=1 -> RELEASE;
- else TX non-empty -> ISSUE;
- else remain in CAPTURE with cs_n=0, the push already done, waiting for TX data.
REQ-030 CAPTURE with the RX FIFO full: stall; no push; cs_n stays 0; drv_start stays 0.
REQ-031 RELEASE: cs_n=1 for CS_HOLD cycles, then IDLE.
REQ-032 Byte-to-byte latency within a frame: drv_start re-asserts 2 cycles after drv_done (CAPTURE, then ISSUE) when TX is non-empty and RX is not full.
REQ-033 drv_data_in holds its last value between transfers.

Reset
REQ-034 While rst=0, every output takes its reset value:
- cs_n=1, drv_start=0, drv_data_in=0, busy=0;
- wr_ready=1, rd_valid=0, rd_data=0;
- both FIFOs empty; state=IDLE.
REQ-035 Reset asserted mid-frame aborts the frame immediately: cs_n goes to 1 asynchronously and all FIFO contents are discarded.
REQ-036 After reset release, the first drv_start occurs no earlier than CS_SETUP+1 cycles after the first TX push.

Verification
REQ-037 Single byte: push 0xA5 with last=1; driver returns 0x3C -> drv_start once with drv_data_in=0xA5; cs_n low CS_SETUP cycles before it; rd_data=0x3C with rd_valid; cs_n high after drv_done; busy=0 after CS_HOLD.
REQ-038 Three-byte frame: push 0x01, 0x02, 0x03 (last on 0x03) -> cs_n stays low continuously across three drv_start pulses spaced 2 cycles after each drv_done; RX order is preserved.
REQ-039 Back-pressure: keep rd_ready=0 and send a 6-byte frame with DEPTH=4 -> 4 bytes captured, then stall in CAPTURE with cs_n=0 and no drv_start; raise rd_ready -> the remaining bytes complete with none lost.
REQ-040 TX full / wrap-around: push 4 bytes while the driver is stalled -> wr_ready=0; a 5th push is blocked; drain and refill 4 more -> the pointers wrap and all 8 bytes go out in order.
REQ-041 Reset mid-frame: assert rst during WAIT of byte 2 -> cs_n=1, rd_valid=0, wr_ready=1 immediately; a new frame after release behaves as in REQ-037.
REQ-042 Spurious drv_done while IDLE -> no RX push and no state change.
